fetch_byte_queue: RTL

- Sits directly upstream of decode stage 0 and produces its whole fetch interface.
- Accepts aligned 16-byte instruction lines from the I-cache streamer into a 32-byte byte queue.
- Presents a 128-bit window to decode. The byte at f_pc is in the MSB byte, f_instruction[127:120].
- Retires the number of bytes decode reports consumed each cycle, and handles pipeline redirects (flush) to unaligned targets.

---
 rtl/fetch_byte_queue_if.sv | 44 ++++
 rtl/fetch_byte_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_byte_queue_if
//   Groups the fetch-side signals of the byte queue: redirect (flush), the
//   I-cache line stream and the decode window.
//   master : the byte queue. It drives ic_ready and the decode-facing f_*
//            outputs, and receives flush, lines and decode feedback.
//   slave  : the environment (I-cache streamer, redirect source, decode 0).
// ----------------------------------------------------------------------------
interface fetch_byte_queue_if #(
    parameter int IADDRW = 32
);
    // redirect
    logic              flush;
    logic [IADDRW-1:0] flush_pc;
    logic              flush_taken;
    // I-cache line stream
    logic              ic_valid;
    logic              ic_ready;
    logic [127:0]      ic_data;
    // decode window
    logic              f_valid;
    logic              f_ready;
    logic [5:0]        f_bytes_read;
    logic [6:0]        f_valid_bytes;
    logic [127:0]      f_instruction;
    logic [IADDRW-1:0] f_pc;
    logic              f_branch_taken;

    modport master (
        input  flush, flush_pc, flush_taken,
        input  ic_valid, ic_data,
        output ic_ready,
        input  f_ready, f_bytes_read,
        output f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken
    );

    modport slave (
        output flush, flush_pc, flush_taken,
        output ic_valid, ic_data,
        input  ic_ready,
        output f_ready, f_bytes_read,
        input  f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken
    );
endinterface

// File: rtl/fetch_byte_queue.sv
// ----------------------------------------------------------------------------
// fetch_byte_queue
//   32-byte instruction byte queue between the I-cache streamer and decode 0.
//   Aligned 16-byte lines are appended behind the valid bytes; decode sees a
//   16-byte window whose byte 0 (address f_pc) sits in f_instruction[127:120].
//   Each cycle decode may retire 1..16 bytes; a flush redirects to an
//   arbitrary byte address, and the leading bytes of the first aligned line
//   after the redirect are dropped.
//
// Ports
//   clk, reset  : clock, asynchronous active-high reset
//   fetch_io    : fetch_byte_queue_if.master
//                 flush/flush_pc/flush_taken  redirect
//                 ic_valid/ic_ready/ic_data   line stream in
//                 f_valid/f_ready/f_bytes_read/f_valid_bytes/
//                 f_instruction/f_pc/f_branch_taken   decode window out
// ----------------------------------------------------------------------------

// One byte lane of the queue. Each lane picks its next value from either the
// current queue shifted by the consume amount, the incoming line, or zero.
module fbq_byte_lane #(
    parameter int LANE       = 0,
    parameter int NUM_LANES  = 32,
    parameter int LINE_BYTES = 16,
    parameter int VEC_W      = 8,
    parameter int CW         = 6
) (
    input  logic [0:NUM_LANES-1][VEC_W-1:0]  queue_i,
    input  logic [0:LINE_BYTES-1][VEC_W-1:0] line_i,
    input  logic [CW-1:0]                    k_i,     // bytes consumed this cycle
    input  logic [CW-1:0]                    base_i,  // valid bytes left after consume
    input  logic [3:0]                       skip_i,  // leading line bytes to drop
    input  logic                             acc_i,   // line accepted this cycle
    output logic [VEC_W-1:0]                 byte_o
);
    localparam int IW = $clog2(NUM_LANES);
    localparam int LW = $clog2(LINE_BYTES);
    localparam logic [CW:0] LANE_C = (CW+1)'(LANE);
    localparam logic [CW:0] NL_C   = (CW+1)'(NUM_LANES);
    localparam logic [CW:0] LB_C   = (CW+1)'(LINE_BYTES);

    logic [CW:0]   src;
    logic [CW:0]   win_end;
    logic [LW-1:0] off;

    always_comb begin
        byte_o  = '0;
        // source position in the old queue for a surviving byte
        src     = LANE_C + {1'b0, k_i};
        // appended bytes occupy [base, base + 16 - skip)
        win_end = {1'b0, base_i} + LB_C - (CW+1)'(skip_i);
        // line byte landing here: first kept byte (skip) goes to lane base
        off     = LW'(LANE_C - {1'b0, base_i} + (CW+1)'(skip_i));
        if (LANE_C < {1'b0, base_i}) begin
            if (src < NL_C) begin
                byte_o = queue_i[src[IW-1:0]];
            end
        end else if (acc_i && (LANE_C < win_end)) begin
            byte_o = line_i[off];
        end
    end
endmodule

module fetch_byte_queue #(
    parameter int                IADDRW   = 32,
    parameter logic [IADDRW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_byte_queue_if.master fetch_io
);
    localparam int NUM_LANES  = 32;
    localparam int LINE_BYTES = 16;
    localparam int VEC_W      = 8;
    localparam int CW         = 6;

    // byte 0 of each array is the most significant byte
    logic [0:NUM_LANES-1][VEC_W-1:0]  queue_q, queue_d;
    logic [0:NUM_LANES-1][VEC_W-1:0]  lane_bytes;
    logic [0:LINE_BYTES-1][VEC_W-1:0] line;
    logic [0:LINE_BYTES-1][VEC_W-1:0] win;
    logic [CW-1:0]                    count_q, count_d;
    logic [IADDRW-1:0]                pc_q, pc_d;
    logic [3:0]                       skip_q, skip_d;
    logic                             taken_q, taken_d;

    logic          f_valid;
    logic          ic_ready;
    logic          cons;
    logic          acc;
    logic [CW-1:0] rd;
    logic [CW-1:0] k;
    logic [CW-1:0] base;
    logic [4:0]    n_in;

    // ------------------------------------------------------------------
    // Outputs: functions of registered state only
    // ------------------------------------------------------------------
    assign f_valid  = (count_q != '0);
    assign ic_ready = (count_q <= CW'(LINE_BYTES));

    // Bytes at or beyond count are forced to zero in the window.
    for (genvar w = 0; w < LINE_BYTES; w++) begin : g_win
        assign win[w] = (CW'(w) < count_q) ? queue_q[w] : '0;
    end

    assign fetch_io.f_valid        = f_valid;
    assign fetch_io.ic_ready       = ic_ready;
    assign fetch_io.f_valid_bytes  = {1'b0, count_q};
    assign fetch_io.f_instruction  = win;
    assign fetch_io.f_pc           = pc_q;
    assign fetch_io.f_branch_taken = taken_q;

    // ------------------------------------------------------------------
    // Consume / append bookkeeping
    // ------------------------------------------------------------------
    assign cons = f_valid & fetch_io.f_ready;
    assign acc  = fetch_io.ic_valid & ic_ready;
    assign rd   = fetch_io.f_bytes_read;
    // Clamp to count so an over-long retire cannot underflow the queue.
    assign k    = cons ? ((rd > count_q) ? count_q : rd) : '0;
    assign base = count_q - k;
    assign n_in = 5'd16 - {1'b0, skip_q};
    assign line = fetch_io.ic_data;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fbq_byte_lane #(
            .LANE       (i),
            .NUM_LANES  (NUM_LANES),
            .LINE_BYTES (LINE_BYTES),
            .VEC_W      (VEC_W),
            .CW         (CW)
        ) u_lane (
            .queue_i (queue_q),
            .line_i  (line),
            .k_i     (k),
            .base_i  (base),
            .skip_i  (skip_q),
            .acc_i   (acc),
            .byte_o  (lane_bytes[i])
        );
    end

    always_comb begin
        queue_d = lane_bytes;
        count_d = base + (acc ? {1'b0, n_in} : '0);
        pc_d    = pc_q + IADDRW'(k);
        skip_d  = acc ? 4'd0 : skip_q;
        taken_d = cons ? 1'b0 : taken_q;
        // Redirect wins over same-cycle consume and append.
        if (fetch_io.flush) begin
            queue_d = '0;
            count_d = '0;
            pc_d    = fetch_io.flush_pc;
            skip_d  = fetch_io.flush_pc[3:0];
            taken_d = fetch_io.flush_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue_q <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            skip_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            queue_q <= queue_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
            taken_q <= taken_d;
        end
    end
endmodule
